instr_line_fill_responder: RTL and testbench

//  Memory-side responder for the L1 instruction-cache line-fill interface.

---
 rtl/instr_line_fill_responder.sv | 114 +++++++++++
 tb/tb_instr_line_fill_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_line_fill_responder.sv
// Instruction line-fill responder: returns an 8-word line from a backing store after LATENCY cycles.
// Latency: accept edge N -> mem_valid during the cycle after edge N+LATENCY; no backpressure, the requester holds mem_req.
// Optional `INSTR_FILL_STATS_EN adds the fill_count output; the preload port writes words in any state.
module instr_line_fill_responder #(
    parameter int LATENCY        = 8,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         mem_req,
    input  logic [31:0]  mem_address,
    output logic [255:0] mem_data,
    output logic         mem_valid,
    output logic         busy,
    input  logic         load_en,
    input  logic [31:0]  load_addr,
    input  logic [31:0]  load_data
`ifdef INSTR_FILL_STATS_EN
    ,
    output logic [31:0]  fill_count
`endif
);

    localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
    localparam int LINE_W = MEM_WORDS_LOG2 - 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_VALID,
        ST_RELEASE
    } state_t;

    state_t            state;
    logic [7:0]        lat_cnt;
    logic [LINE_W-1:0] line_addr;
    logic [255:0]      line_dat;
    logic [31:0]       store [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[31:MEM_WORDS_LOG2+2], mem_address[4:0],
                                load_addr[31:MEM_WORDS_LOG2+2], load_addr[1:0]};

    // Store is deliberately not reset so a preloaded program survives RESET.
    always_ff @(posedge CLK) begin
        if (load_en) begin
            store[load_addr[MEM_WORDS_LOG2+1:2]] <= load_data;
        end
    end

    // Offset 0 lands in the most significant word of the line.
    always_comb begin
        line_dat = '0;
        for (int i = 0; i < 8; i++) begin
            line_dat[255-32*i -: 32] = store[{line_addr, 3'(i)}];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            line_addr  <= '0;
            mem_data   <= '0;
            mem_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef INSTR_FILL_STATS_EN
            fill_count <= '0;
`endif
        end else begin
            mem_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        state     <= ST_WAIT;
                        busy      <= 1'b1;
                        line_addr <= mem_address[MEM_WORDS_LOG2+1:5];
                        lat_cnt   <= 8'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (!mem_req) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (lat_cnt == 8'd0) begin
                        // Old store contents are captured; a same-edge load lands afterwards.
                        state     <= ST_VALID;
                        mem_valid <= 1'b1;
                        mem_data  <= line_dat;
`ifdef INSTR_FILL_STATS_EN
                        fill_count <= fill_count + 32'd1;
`endif
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                ST_VALID: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!mem_req) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_line_fill_responder.sv
// Bench for instr_line_fill_responder: event-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requests, aborts and preload writes.
module tb_instr_line_fill_responder;

    localparam int LAT = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         mem_req = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_data;
    logic         mem_valid;
    logic         busy;
    logic         load_en = 1'b0;
    logic [31:0]  load_addr = '0;
    logic [31:0]  load_data = '0;
`ifdef INSTR_FILL_STATS_EN
    logic [31:0]  fill_count;
`endif

    instr_line_fill_responder #(.LATENCY(LAT), .MEM_WORDS_LOG2(12)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .mem_req(mem_req),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_valid(mem_valid),
        .busy(busy),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data)
`ifdef INSTR_FILL_STATS_EN
        ,
        .fill_count(fill_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    bit chk_en = 1'b0;
    logic [31:0] pre [64];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding request by absolute edge numbers.
    bit [31:0]   m_mem [4096];
    int          ecnt = 0;
    bit          m_pending = 0;
    bit          m_holding = 0;
    bit          m_valid = 0;
    int          m_due = 0;
    int          m_vedge = 0;
    int unsigned m_line = 0;
    logic [255:0] m_data = '0;
    int unsigned m_fills = 0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_pending = 0;
            m_holding = 0;
            m_valid   = 0;
            m_data    = '0;
            m_fills   = 0;
        end else begin
            ecnt++;
            m_valid = 0;
            if (m_pending) begin
                if (!mem_req) begin
                    m_pending = 0;
                end else if (ecnt == m_due) begin
                    m_pending = 0;
                    m_holding = 1;
                    m_valid   = 1;
                    m_vedge   = ecnt;
                    m_fills++;
                    for (int i = 0; i < 8; i++) m_data[255-32*i -: 32] = m_mem[m_line*8 + i];
                end
            end else if (m_holding) begin
                if (ecnt >= m_vedge + 2 && !mem_req) m_holding = 0;
            end else if (mem_req) begin
                m_pending = 1;
                m_due     = ecnt + LAT;
                m_line    = (mem_address >> 5) & 32'd511;
            end
            if (load_en) m_mem[(load_addr >> 2) & 32'd4095] = load_data;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("mem_valid", 256'(mem_valid), 256'(m_valid));
            check("busy", 256'(busy), 256'(m_pending | m_holding));
            check("mem_data", mem_data, m_data);
`ifdef INSTR_FILL_STATS_EN
            check("fill_count", 256'(fill_count), 256'(m_fills));
`endif
        end
        if (mem_valid) pulses++;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] line_of(input int base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = pre[base + i];
        return r;
    endfunction

    // Request, then count edges after the accept edge until mem_valid appears.
    task automatic fill(input logic [31:0] a, output int lat);
        mem_req = 1'b1;
        mem_address = a;
        tick;
        lat = 0;
        while (!mem_valid && lat < 300) begin
            tick;
            lat++;
        end
    endtask

    task automatic drop;
        mem_req = 1'b0;
        tick;
        tick;
    endtask

    task automatic rand_load;
        logic [31:0] a;
        load_en = ($urandom_range(0, 3) == 0);
        a = $urandom;
        a[13:2] = 12'($urandom_range(0, 63));
        load_addr = a;
        load_data = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        logic [31:0] w;
        logic [31:0] a;
        int abort_at;

        for (int i = 0; i < 64; i++) pre[i] = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
        #2 RESET = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) tick;
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_data", mem_data, 256'(0));
        RESET = 1'b1;
        tick;

        for (int i = 0; i < 64; i++) begin
            load_en = 1'b1;
            load_addr = 32'(i * 4);
            load_data = pre[i];
            tick;
        end
        load_en = 1'b0;
        tick;

        // Scenario 1: basic fill with full latency.
        fill(32'h0000_0004, lat);
        check("t1_latency", 256'(lat), 256'(8));
        check("t1_data", mem_data,
              256'h10000000_10000001_10000002_10000003_10000004_10000005_10000006_10000007);
        p0 = pulses;

        // Scenario 2: minimum turnaround to a second request.
        tick;
        mem_req = 1'b0;
        tick;
        check("t2_idle_busy", 256'(busy), 256'(0));
        mem_req = 1'b1;
        mem_address = 32'h20;
        tick;
        check("t2_accept_busy", 256'(busy), 256'(1));
        lat = 0;
        while (!mem_valid && lat < 300) begin
            tick;
            lat++;
        end
        check("t2_latency", 256'(lat), 256'(8));
        check("t2_data", mem_data, line_of(8));
        drop;
        check("t2_pulses", 256'(pulses - p0), 256'(2));

        // Scenario 3: abort while waiting.
        p0 = pulses;
        mem_req = 1'b1;
        mem_address = 32'h40;
        tick;
        repeat (4) tick;
        mem_req = 1'b0;
        tick;
        check("t3_busy", 256'(busy), 256'(0));
        repeat (12) tick;
        check("t3_no_valid", 256'(pulses - p0), 256'(0));
        check("t3_data_kept", mem_data, line_of(8));

        // Scenario 4: load on the VALID-transition edge is not returned.
        mem_req = 1'b1;
        mem_address = 32'h60;
        tick;
        repeat (7) tick;
        load_en = 1'b1;
        load_addr = 32'h6C;
        load_data = 32'hDEAD_BEEF;
        tick;
        load_en = 1'b0;
        check("t4_valid", 256'(mem_valid), 256'(1));
        w = mem_data[159:128];
        check("t4_old_word", 256'(w), 256'(pre[27]));
        drop;
        fill(32'h60, lat);
        w = mem_data[159:128];
        check("t4_new_word", 256'(w), 256'(32'hDEAD_BEEF));
        drop;

        // Scenario 5: reset in the middle of a fill.
        mem_req = 1'b1;
        mem_address = 32'h80;
        tick;
        repeat (3) tick;
        RESET = 1'b0;
        #1;
        check("t5_valid", 256'(mem_valid), 256'(0));
        check("t5_busy", 256'(busy), 256'(0));
        check("t5_data", mem_data, 256'(0));
        mem_req = 1'b0;
        tick;
        RESET = 1'b1;
        tick;
        fill(32'h80, lat);
        check("t5_latency", 256'(lat), 256'(8));
        check("t5_line", mem_data, line_of(32));
        drop;

        // Scenario 6: fill statistics across reset, fills and an abort.
        RESET = 1'b0;
        #1;
`ifdef INSTR_FILL_STATS_EN
        check("t6_count_reset", 256'(fill_count), 256'(0));
`endif
        tick;
        RESET = 1'b1;
        tick;
        for (int k = 0; k < 3; k++) begin
            fill(32'(k * 32), lat);
            drop;
        end
        mem_req = 1'b1;
        mem_address = 32'hA0;
        tick;
        repeat (2) tick;
        mem_req = 1'b0;
        repeat (3) tick;
`ifdef INSTR_FILL_STATS_EN
        check("t6_count", 256'(fill_count), 256'(3));
`endif

        // Randomized requests with aborts, wrapped addresses and concurrent preload writes.
        for (int t = 0; t < 80; t++) begin
            a = $urandom;
            a[13:5] = 9'($urandom_range(0, 7));
            mem_req = 1'b1;
            mem_address = a;
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 1000;
            rand_load;
            tick;
            for (int n = 1; n < 40; n++) begin
                if (mem_valid || n == abort_at) break;
                rand_load;
                tick;
            end
            repeat ($urandom_range(0, 3)) begin
                rand_load;
                tick;
            end
            mem_req = 1'b0;
            repeat ($urandom_range(2, 4)) begin
                rand_load;
                tick;
            end
        end
        load_en = 1'b0;
        repeat (4) tick;

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
